// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the multi-cycle data-memory responder.
//   state_t        FSM encoding (IDLE, BUSY, RESP)
//   DMEM_LATENCY   default request-to-response latency in cycles (1..15)
//   DMEM_ADDR_W    default number of implemented word-address bits
//   DMEM_CNT_W     latency counter width
package dmem_pkg;

  localparam int DMEM_LATENCY = 4;
  localparam int DMEM_ADDR_W  = 13;
  localparam int DMEM_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2**ADDR_W x 16 word storage.
//   i_clk    clock
//   i_rst_n  async active-low reset, clears only the read-data register
//   i_addr   word address
//   i_we     synchronous write enable
//   i_wdata  write data
//   i_re     synchronous read enable; o_rdata holds between reads
//   o_rdata  registered read data
// Storage is never cleared by reset.
module dmem_array #(
  parameter int ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [15:0]       i_wdata,
  input  logic              i_re,
  output logic [15:0]       o_rdata
);

  logic [15:0] r_mem [0:(2**ADDR_W)-1];
  logic [15:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Read register kept apart from the storage so only it sees the reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_rdata <= 16'h0000;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time data-memory responder with fixed latency.
//   i_clk, i_rst_n      clock, async active-low reset
//   i_req_valid/o_req_ready  request handshake (ready = state is IDLE)
//   i_req_wr            1 = store, 0 = load
//   i_req_addr          word address, bits above ADDR_W-1 ignored
//   i_req_wdata         store data
//   o_rsp_valid         one-cycle response strobe
//   o_rsp_rdata         last load data (held until the next load response)
// Optional feature macro: DMEM_WR_ACK_EN -- stores also pulse o_rsp_valid.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = DMEM_LATENCY,
  parameter int ADDR_W  = DMEM_ADDR_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wr,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_rdata
);

  // Accept cycle plus LATENCY-1 counted cycles lands RESP LATENCY cycles out.
  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD =
    (LATENCY >= 2) ? DMEM_CNT_W'(LATENCY - 2) : '0;

  state_t                r_state, w_next;
  logic [DMEM_CNT_W-1:0] r_cnt;
  logic                  r_wr;
  logic [ADDR_W-1:0]     r_addr;
  logic [15:0]           r_wdata;

  logic                  w_acc, w_enter_resp, w_op_wr;
  logic [ADDR_W-1:0]     w_op_addr;
  logic [15:0]           w_op_wdata;

  generate
    if (ADDR_W < 16) begin : g_unused
      logic w_unused_addr;
      assign w_unused_addr = ^i_req_addr[15:ADDR_W];
    end
  endgenerate

  assign w_acc = (r_state == IDLE) && i_req_valid;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_req_valid) w_next = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (r_cnt == '0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_req_ready = (r_state == IDLE);
`ifdef DMEM_WR_ACK_EN
    o_rsp_valid = (r_state == RESP);
`else
    o_rsp_valid = (r_state == RESP) && !r_wr;
`endif
  end

  // Request latch and latency counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 16'h0000;
    end else if (w_acc) begin
      r_cnt   <= CNT_LOAD;
      r_wr    <= i_req_wr;
      r_addr  <= i_req_addr[ADDR_W-1:0];
      r_wdata <= i_req_wdata;
    end else if (r_state == BUSY && r_cnt != '0) begin
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  // With LATENCY==1 RESP is entered straight from IDLE, before the latch
  // holds the request, so the array is fed from the live inputs then.
  assign w_enter_resp = (w_next == RESP) && (r_state != RESP);
  assign w_op_wr      = (r_state == IDLE) ? i_req_wr                : r_wr;
  assign w_op_addr    = (r_state == IDLE) ? i_req_addr[ADDR_W-1:0]  : r_addr;
  assign w_op_wdata   = (r_state == IDLE) ? i_req_wdata             : r_wdata;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_addr  (w_op_addr),
    .i_we    (w_enter_resp && w_op_wr),
    .i_wdata (w_op_wdata),
    .i_re    (w_enter_resp && !w_op_wr),
    .o_rdata (o_rsp_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 at LATENCY=4, instance 1 at LATENCY=1.
// Drivers push expected responses (data and arrival time) into per-instance
// queues; a negedge monitor pops and compares whenever o_rsp_valid is high.
module tb_dmem_responder;

  localparam bit ACK =
`ifdef DMEM_WR_ACK_EN
    1'b1;
`else
    1'b0;
`endif
  localparam int P = 10;
  localparam int LAT [2] = '{4, 1};

  typedef struct { logic [15:0] d; time t; } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v   [2];
  logic        wr  [2];
  logic [15:0] a   [2];
  logic [15:0] d   [2];
  logic        rdy [2];
  logic        rv  [2];
  logic [15:0] rd  [2];

  exp_t        q0[$], q1[$];
  logic [15:0] last [2];
  time         acc_t [2];
  int          rcnt [2];
  int          tests = 0;
  int          fails = 0;

  always #(P/2) clk = ~clk;

  dmem_responder #(.LATENCY(4), .ADDR_W(13)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v[0]), .o_req_ready(rdy[0]),
    .i_req_wr(wr[0]), .i_req_addr(a[0]), .i_req_wdata(d[0]),
    .o_rsp_valid(rv[0]), .o_rsp_rdata(rd[0]));

  dmem_responder #(.LATENCY(1), .ADDR_W(13)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v[1]), .o_req_ready(rdy[1]),
    .i_req_wr(wr[1]), .i_req_addr(a[1]), .i_req_wdata(d[1]),
    .o_rsp_valid(rv[1]), .o_rsp_rdata(rd[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a request on instance s and return 1 time unit after the accept
  // edge. For loads dt is the expected read data. noexp: no response expected.
  task automatic issue(input int s, input logic w, input logic [15:0] ad,
                       input logic [15:0] dt, input bit noexp, input bit keep);
    int   n;
    exp_t e;
    v[s] = 1'b1; wr[s] = w; a[s] = ad; d[s] = dt;
    n = 0;
    do begin @(negedge clk); n++; end while (rdy[s] !== 1'b1 && n < 40);
    if (rdy[s] !== 1'b1) begin
      tests++; fails++;
      $display("FAIL accept_timeout: inst %0d never ready, expected ready", s);
    end
    if (!noexp && (!w || ACK)) begin
      e.d = w ? last[s] : dt;
      e.t = $time + LAT[s] * P;
      if (s == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (!w && !noexp) last[s] = dt;
    @(posedge clk);
    acc_t[s] = $time;
    #1;
    if (!keep) v[s] = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (rv[s] === 1'b1) begin
          rcnt[s]++;
          if ((s == 0 ? q0.size() : q1.size()) == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_rsp: inst %0d rsp_valid=1, expected 0 at %0t", s, $time);
          end else begin
            e = (s == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rsp_rdata[%0d]", s), {16'h0, rd[s]}, {16'h0, e.d});
            chk($sformatf("rsp_time[%0d]", s), 32'($time), 32'(e.t));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_prev;
    int  c;
    for (int s = 0; s < 2; s++) begin
      v[s] = 1'b0; wr[s] = 1'b0; a[s] = 16'h0; d[s] = 16'h0;
      last[s] = 16'h0; rcnt[s] = 0; acc_t[s] = 0;
    end

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_ready", 32'(rdy[s]), 32'd1);
      chk("reset_rsp_valid", 32'(rv[s]), 32'd0);
      chk("reset_rdata", {16'h0, rd[s]}, 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store then load same address, back to back: accepts 5 cycles apart
    issue(0, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0);
    t_prev = acc_t[0];
    issue(0, 1'b0, 16'h0010, 16'h1234, 1'b0, 1'b0);
    chk("throughput_spacing", 32'(acc_t[0] - t_prev), 32'(5 * P));
    // ready low through BUSY and RESP, back high after
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ready_low", 32'(rdy[0]), 32'd0);
    end
    @(negedge clk);
    chk("ready_back", 32'(rdy[0]), 32'd1);
    drain();

    // Aliasing above ADDR_W
    issue(0, 1'b1, 16'h2005, 16'hBEEF, 1'b0, 1'b0);
    issue(0, 1'b0, 16'h0005, 16'hBEEF, 1'b0, 1'b0);
    drain();

    // Store acknowledgement present only in the ack build; rdata unchanged
    c = rcnt[0];
    issue(0, 1'b1, 16'h0030, 16'h7777, 1'b0, 1'b0);
    drain();
    chk("store_ack_pulses", 32'(rcnt[0] - c), ACK ? 32'd1 : 32'd0);
    chk("store_rdata_held", {16'h0, rd[0]}, {16'h0, last[0]});

    // Reset mid-BUSY aborts a store
    issue(0, 1'b1, 16'h0020, 16'h5555, 1'b0, 1'b0);
    drain();
    issue(0, 1'b1, 16'h0020, 16'hAAAA, 1'b1, 1'b0);
    @(posedge clk); #1;
    c = rcnt[0];
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(rdy[0]), 32'd1);
    chk("abort_rsp_valid", 32'(rv[0]), 32'd0);
    chk("abort_rdata", {16'h0, rd[0]}, 32'h0);
    last[0] = 16'h0; last[1] = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drain();
    chk("abort_no_rsp", 32'(rcnt[0] - c), 32'd0);
    issue(0, 1'b0, 16'h0020, 16'h5555, 1'b0, 1'b0);
    drain();
    chk("abort_prior_data", {16'h0, rd[0]}, 32'h5555);

    // LATENCY=1: preload, then loads with req_valid held high
    issue(1, 1'b1, 16'h0001, 16'h0101, 1'b0, 1'b0);
    issue(1, 1'b1, 16'h0002, 16'h0202, 1'b0, 1'b0);
    issue(1, 1'b1, 16'h0003, 16'h0303, 1'b0, 1'b0);
    drain();
    issue(1, 1'b0, 16'h0001, 16'h0101, 1'b0, 1'b1);
    t_prev = acc_t[1];
    issue(1, 1'b0, 16'h0002, 16'h0202, 1'b0, 1'b1);
    chk("lat1_spacing_a", 32'(acc_t[1] - t_prev), 32'(2 * P));
    t_prev = acc_t[1];
    issue(1, 1'b0, 16'h0003, 16'h0303, 1'b0, 1'b0);
    chk("lat1_spacing_b", 32'(acc_t[1] - t_prev), 32'(2 * P));
    drain();

    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
